// File: rtl/pipe_defs.sv
// Shared pipeline definitions: control word layout and hazard controller state encoding.
package pipe_defs;

  localparam int unsigned CTRL_W = 13;

  // Same value the ID/EX register holds after reset, so a bubble looks like a reset slot.
  localparam logic [CTRL_W-1:0] CTRL_NOP = 13'h0001;

  localparam int unsigned CTRL_MEM_READ = 4;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the ID/EX stage: load-use stalls, taken-branch flushes and
// multi-cycle EX holds, plus a saturating count of stalled cycles.
module hazard_ctrl
  import pipe_defs::*;
#(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ex_control,
  input  logic [4:0]        id_ex_rt,
  input  logic [4:0]        if_id_rs,
  input  logic [4:0]        if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              ex_branch_taken,
  input  logic              ex_mc_start,
  input  logic              perf_clr,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_hold,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned McCntW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
  localparam logic [McCntW-1:0] McLoad = McCntW'(MC_LATENCY - 2);

  hz_state_e         r_state;
  logic [McCntW-1:0] r_mc_cnt;

  logic w_load_use;
  logic w_busy;
  logic w_go_busy;
  logic w_stall_inc;
  logic w_unused_ctrl;

  assign w_unused_ctrl = ^id_ex_control;

  assign w_load_use = id_ex_control[CTRL_MEM_READ] && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  // Busy only while cycles remain; the mc_cnt==0 cycle behaves like RUN minus mc_start.
  assign w_busy = (r_state == MC_BUSY) && (r_mc_cnt != '0);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    w_go_busy    = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_hold     = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if ((r_state == RUN) && ex_mc_start) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_hold     = 1'b1;
      w_go_busy   = 1'b1;
    end else if (w_load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_mc_cnt <= '0;
    end else if (w_go_busy) begin
      r_state  <= MC_BUSY;
      r_mc_cnt <= McLoad;
    end else if (w_busy) begin
      r_mc_cnt <= r_mc_cnt - McCntW'(1);
    end else begin
      r_state <= RUN;
    end
  end

  assign w_stall_inc = !reset && !pc_write;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .i_clr   (perf_clr),
    .o_count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-scenario tasks with a queue of expected output vectors.
module tb_hazard_ctrl;
  import pipe_defs::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [CTRL_W-1:0] id_ex_control;
  logic [4:0]        id_ex_rt, if_id_rs, if_id_rt;
  logic              if_id_uses_rt, ex_branch_taken, ex_mc_start, perf_clr, perf_clr4;
  logic              pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold;
  logic              pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, ex_hold4;
  logic [31:0]       stall_cycles;
  logic [3:0]        stall_cycles4;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_LATENCY(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_ex_control(id_ex_control), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .perf_clr(perf_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_ex_control(id_ex_control), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .perf_clr(perf_clr4),
    .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
    .id_ex_bubble(id_ex_bubble4), .ex_hold(ex_hold4), .stall_cycles(stall_cycles4)
  );

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold}
  localparam logic [4:0] E_RUN = 5'b11000;
  localparam logic [4:0] E_RST = 5'b00110;
  localparam logic [4:0] E_LU  = 5'b00010;
  localparam logic [4:0] E_MC  = 5'b00001;
  localparam logic [4:0] E_BR  = 5'b11110;

  logic [4:0]        obs;
  logic [4:0]        exp_v;
  logic [4:0]        q_exp[$];
  logic [CTRL_W-1:0] ctrl_ld;
  int                total = 0;
  int                bad = 0;

  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold};

  task automatic drive(input logic r, input logic ld, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses, input logic br, input logic mc);
    reset           = r;
    id_ex_control   = ld ? ctrl_ld : CTRL_NOP;
    id_ex_rt        = ert;
    if_id_rs        = rs;
    if_id_rt        = rt;
    if_id_uses_rt   = uses;
    ex_branch_taken = br;
    ex_mc_start     = mc;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      q_exp.push_back(E_RST);
      #1 exp_v = q_exp.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_outs cyc=%0d got=%b want=%b", i, obs, exp_v); end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    q_exp.push_back(E_RUN);
    #1 exp_v = q_exp.pop_front();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_release got=%b want=%b", obs, exp_v); end
    total++;
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_load_use();
    logic [4:0] pat_e[6];
    pat_e = '{E_LU, E_RUN, E_RUN, E_RUN, E_LU, E_RUN};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      case (i)
        0: drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
        1: drive(1'b0, 1'b0, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
        2: drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        3: drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        4: drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        default: drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      endcase
      q_exp.push_back(pat_e[i]);
      #1 exp_v = q_exp.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL load_use step=%0d got=%b want=%b", i, obs, exp_v); end
      if (i == 1) begin
        total++;
        if (stall_cycles !== 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cycles); end
      end
    end
    total++;
    if (stall_cycles !== 32'd2) begin bad++; $display("FAIL lu_cnt2 got=%0d want=2", stall_cycles); end
  endtask

  task automatic test_multicycle();
    logic [4:0] pat_e[5];
    pat_e = '{E_MC, E_MC, E_MC, E_RUN, E_RUN};
    @(negedge clk);
    perf_clr = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    perf_clr = 1'b0;
    total++;
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL mc_clr got=%0d want=0", stall_cycles); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      // Branch during the held cycle must be ignored.
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, i == 1, i < 4);
      q_exp.push_back(pat_e[i]);
      #1 exp_v = q_exp.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL multicycle cyc=%0d got=%b want=%b", i + 1, obs, exp_v); end
    end
    total++;
    if (stall_cycles !== 32'd3) begin bad++; $display("FAIL mc_cnt got=%0d want=3", stall_cycles); end
  endtask

  task automatic test_branch_priority();
    logic [4:0] pat_e[2];
    pat_e = '{E_BR, E_RUN};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
      else        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      q_exp.push_back(pat_e[i]);
      #1 exp_v = q_exp.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL branch_prio step=%0d got=%b want=%b", i, obs, exp_v); end
    end
    total++;
    if (stall_cycles !== 32'd3) begin bad++; $display("FAIL br_cnt got=%0d want=3", stall_cycles); end
  endtask

  task automatic test_reset_in_busy();
    logic [4:0] pat_e[4];
    pat_e = '{E_MC, E_MC, E_RST, E_RUN};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(i == 2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, i < 3);
      q_exp.push_back(pat_e[i]);
      #1 exp_v = q_exp.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rst_busy step=%0d got=%b want=%b", i, obs, exp_v); end
    end
    total++;
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_busy_cnt got=%0d want=0", stall_cycles); end
  endtask

  task automatic test_saturate();
    int m;
    @(negedge clk);
    perf_clr4 = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    perf_clr4 = 1'b0;
    m = 0;
    total++;
    if (stall_cycles4 !== 4'd0) begin bad++; $display("FAIL sat_clr0 got=%0d want=0", stall_cycles4); end
    for (int i = 0; i < 21; i++) begin
      if (i > 0) @(negedge clk);
      if (i > 0) begin
        m = (m == 15) ? 15 : m + 1;
        total++;
        if (stall_cycles4 !== 4'(m)) begin bad++; $display("FAIL sat_cnt cyc=%0d got=%0d want=%0d", i, stall_cycles4, m); end
      end
      perf_clr4 = (i == 20);
      drive(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
      q_exp.push_back(E_LU);
      #1 exp_v = q_exp.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL sat_stall cyc=%0d got=%b want=%b", i, obs, exp_v); end
    end
    @(negedge clk);
    perf_clr4 = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (stall_cycles4 !== 4'd0) begin bad++; $display("FAIL sat_clr got=%0d want=0", stall_cycles4); end
  endtask

  initial begin
    ctrl_ld = CTRL_NOP | 13'h0100;
    ctrl_ld[CTRL_MEM_READ] = 1'b1;
    perf_clr  = 1'b0;
    perf_clr4 = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_multicycle();
    test_branch_priority();
    test_reset_in_busy();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
